// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and constants for the FPU add/subtract sequencer
package fpu_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] PINF = 32'h7F80_0000;

   // Working widths: 32-bit significand with hidden one at FRAC_W, 10-bit signed exponent
   localparam int SIG_W  = 32;
   localparam int EXPS_W = 10;
   localparam int LZC_W  = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } fpu_add_state_t;

endpackage

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - leading-one detector giving the left shift that puts the MSB one at the top bit
module fpu_lzc
   import fpu_pkg::*;
#(
   parameter int W = LZC_W
) (
   input  logic [W-1:0]         val_i,
   output logic [$clog2(W)-1:0] shift_o,
   output logic                 zero_o
);

   always_comb begin
      shift_o = '0;
      zero_o  = (val_i == '0);
      // Ascending scan: the highest set bit is the last one to write the count
      for (int i = 0; i < W; i++) begin
         if (val_i[i]) shift_o = ($clog2(W))'(W - 1 - i);
      end
   end

endmodule

// File: rtl/fpu_add_sequencer.sv
// rtl/fpu_add_sequencer.sv - five-phase single-precision add/subtract over one shared datapath
module fpu_add_sequencer
   import fpu_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        overflow
);

   localparam int SGN = EXP_W + FRAC_W;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   fpu_add_state_t state_q, state_d;

   logic              sign_q, eff_sub_q, zero_q, special_q, overflow_q;
   logic [EXPS_W-1:0] exp_q;
   logic [EXP_W-1:0]  expb_q;
   logic [SIG_W-1:0]  siga_q, sigb_q, sum_q;
   logic [31:0]       spec_q, result_q;

   logic              accept;
   logic              a_sign, b_sign, swap, a_max, b_max, a_nan, b_nan;
   logic [EXP_W-1:0]  a_exp, b_exp, big_exp, small_exp;
   logic [FRAC_W-1:0] a_frac, b_frac, big_frac, small_frac;
   logic [31:0]       in_spec_res;

   always_comb begin
      a_sign     = op_a[SGN];
      b_sign     = op_b[SGN] ^ sub;
      a_exp      = op_a[FRAC_W +: EXP_W];
      b_exp      = op_b[FRAC_W +: EXP_W];
      a_frac     = (a_exp == '0) ? '0 : op_a[FRAC_W-1:0];
      b_frac     = (b_exp == '0) ? '0 : op_b[FRAC_W-1:0];
      swap       = {b_exp, b_frac} > {a_exp, a_frac};
      big_exp    = swap ? b_exp : a_exp;
      big_frac   = swap ? b_frac : a_frac;
      small_exp  = swap ? a_exp : b_exp;
      small_frac = swap ? a_frac : b_frac;
      a_max      = (a_exp == EXP_ONES);
      b_max      = (b_exp == EXP_ONES);
      a_nan      = a_max && (op_a[FRAC_W-1:0] != '0);
      b_nan      = b_max && (op_b[FRAC_W-1:0] != '0);
      if (a_nan || b_nan || (a_max && b_max && (a_sign != b_sign))) begin
         in_spec_res = QNAN;
      end else if (a_max) begin
         in_spec_res = PINF | {a_sign, 31'b0};
      end else begin
         in_spec_res = PINF | {b_sign, 31'b0};
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ST_ALIGN;
         end
         ST_ALIGN: state_d = ST_ADD;
         ST_ADD:   state_d = ST_NORM;
         ST_NORM:  state_d = ST_ROUND;
         ST_ROUND: state_d = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_d = in_valid ? ST_ALIGN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   assign accept = in_valid & in_ready;

   logic [EXP_W-1:0]         diff;
   logic [SIG_W:0]           b_shift;
   logic [$clog2(LZC_W)-1:0] lz_shift;
   logic                     lz_zero, norm_zero;
   logic [EXPS_W-1:0]        rnd_exp;
   logic [FRAC_W-1:0]        rnd_frac;

   // Extra LSB catches the last bit shifted out, which becomes the guard round
   assign diff    = exp_q[EXP_W-1:0] - expb_q;
   assign b_shift = {sigb_q, 1'b0} >> diff;

   fpu_lzc #(.W(LZC_W)) u_lzc (
      .val_i   (sum_q[LZC_W-1:0]),
      .shift_o (lz_shift),
      .zero_o  (lz_zero)
   );

   assign norm_zero = lz_zero & ~sum_q[FRAC_W+1];
   assign rnd_frac  = sum_q[FRAC_W+1] ? sum_q[FRAC_W:1] : sum_q[FRAC_W-1:0];
   assign rnd_exp   = exp_q + EXPS_W'(sum_q[FRAC_W+1]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sign_q     <= 1'b0;
         eff_sub_q  <= 1'b0;
         zero_q     <= 1'b0;
         special_q  <= 1'b0;
         exp_q      <= '0;
         expb_q     <= '0;
         siga_q     <= '0;
         sigb_q     <= '0;
         sum_q      <= '0;
         spec_q     <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else if (accept) begin
         sign_q    <= swap ? b_sign : a_sign;
         eff_sub_q <= a_sign ^ b_sign;
         special_q <= a_max | b_max;
         spec_q    <= in_spec_res;
         exp_q     <= EXPS_W'(big_exp);
         expb_q    <= small_exp;
         siga_q    <= SIG_W'({big_exp != '0, big_frac});
         sigb_q    <= SIG_W'({small_exp != '0, small_frac});
      end else begin
         case (state_q)
            ST_ALIGN: sigb_q <= (diff >= EXP_W'(FRAC_W + 2)) ? '0
                                : b_shift[SIG_W:1] + SIG_W'(b_shift[0]);
            ST_ADD:   sum_q  <= eff_sub_q ? siga_q - sigb_q : siga_q + sigb_q;
            ST_NORM: begin
               zero_q <= norm_zero;
               if (sum_q[FRAC_W+1]) begin
                  sum_q <= (sum_q >> 1) + SIG_W'(sum_q[0]);
                  exp_q <= exp_q + EXPS_W'(1);
               end else if (!norm_zero) begin
                  sum_q <= sum_q << lz_shift;
                  exp_q <= exp_q - EXPS_W'(lz_shift);
               end
            end
            ST_ROUND: begin
               overflow_q <= 1'b0;
               if (special_q) begin
                  result_q <= spec_q;
               end else if (zero_q) begin
                  result_q <= '0;
               end else if ($signed(rnd_exp) >= $signed(EXPS_W'(EXP_MAX))) begin
                  result_q   <= PINF | {sign_q, 31'b0};
                  overflow_q <= 1'b1;
               end else if (rnd_exp[EXPS_W-1] || rnd_exp == '0) begin
                  result_q <= {sign_q, 31'b0};
               end else begin
                  result_q <= {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
               end
            end
            default: ;
         endcase
      end
   end

   assign result   = result_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// tb/tb_fpu_add_sequencer.sv - self-checking bench for fpu_add_sequencer
module tb_fpu_add_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   fpu_add_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference result {overflow, result} derived directly from the arithmetic rules
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic   sa, sb, st, nan;
      int     ea, eb, et, e, d;
      longint ma, mb, mt, sum, ka, kb;
      sa = a[31];
      sb = b[31] ^ s;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (ea == 255 || eb == 255) begin
         nan = (ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0);
         if (nan || (ea == 255 && eb == 255 && sa != sb)) return {1'b0, 32'h7FC00000};
         if (ea == 255) return {1'b0, sa, 31'h7F800000};
         return {1'b0, sb, 31'h7F800000};
      end
      ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
      mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
      ka = (ea == 0) ? 0 : longint'(ea) * (longint'(1) << 23) + longint'(a[22:0]);
      kb = (eb == 0) ? 0 : longint'(eb) * (longint'(1) << 23) + longint'(b[22:0]);
      if (kb > ka) begin
         st = sa; sa = sb; sb = st;
         et = ea; ea = eb; eb = et;
         mt = ma; ma = mb; mb = mt;
      end
      d = ea - eb;
      if (d >= 25) mb = 0;
      else if (d > 0) mb = (mb >> d) + ((mb >> (d - 1)) & 1);
      sum = (sa == sb) ? ma + mb : ma - mb;
      if (sum == 0) return 33'h0;
      e = ea;
      if (sum >= (longint'(1) << 24)) begin
         sum = (sum >> 1) + (sum & 1);
         e++;
         if (sum >= (longint'(1) << 24)) begin
            sum = sum >> 1;
            e++;
         end
      end else begin
         while (sum < (longint'(1) << 23)) begin
            sum = sum << 1;
            e--;
         end
      end
      if (e >= 255) return {1'b1, sa, 31'h7F800000};
      if (e <= 0) return {1'b0, sa, 31'h0};
      return {1'b0, sa, 8'(e), 23'(sum)};
   endfunction

   // Scoreboard: expected results with the cycle in which each must first appear
   logic [32:0] q_exp[$];
   int          q_due[$];

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         q_exp.delete();
         q_due.delete();
      end else begin
         chk("in_ready", {32'b0, in_ready},
             {32'b0, (q_exp.size() == 0) || (cyc >= q_due[0] && out_ready)});
         if (q_exp.size() > 0 && cyc >= q_due[0]) begin
            chk("out_valid_due", {32'b0, out_valid}, 33'h1);
            chk("sb_result", {overflow, result}, q_exp[0]);
            if (out_ready) begin
               void'(q_exp.pop_front());
               void'(q_due.pop_front());
            end
         end else begin
            chk("out_valid_idle", {32'b0, out_valid}, 33'h0);
         end
         if (in_valid && in_ready) begin
            q_exp.push_back(model(op_a, op_b, sub));
            q_due.push_back(cyc + 5);
         end
      end
   end

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] r;
      logic        o;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [0:NV-1];

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("issue_timeout", 33'h1, 33'h0);
      in_valid = 1'b1;
      op_a = a;
      op_b = b;
      sub  = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op_a = 32'hDEAD_BEEF;
      op_b = 32'h1234_5678;
      sub  = ~s;
   endtask

   task automatic wait_valid(output logic [32:0] r);
      int n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("wait_valid_timeout", 33'h1, 33'h0);
      r = {overflow, result};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [32:0] r, held;
      int seen;

      vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0};
      vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0};
      vecs[2]  = '{32'h40400000, 32'h40300000, 1'b1, 32'h3E800000, 1'b0};
      vecs[3]  = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0};
      vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1};
      vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0};
      vecs[6]  = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0};
      vecs[7]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0};
      vecs[8]  = '{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 1'b0};
      vecs[9]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0};
      vecs[10] = '{32'h7FC00001, 32'h00000000, 1'b0, 32'h7FC00000, 1'b0};
      vecs[11] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0};
      vecs[12] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h407FFFFF, 1'b0};
      vecs[13] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0};
      vecs[14] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0};

      for (int i = 0; i < NV; i++)
         chk($sformatf("model_pin_%0d", i), model(vecs[i].a, vecs[i].b, vecs[i].s),
             {vecs[i].o, vecs[i].r});

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", {32'b0, in_ready}, 33'h1);
      chk("reset_out_valid", {32'b0, out_valid}, 33'h0);
      chk("reset_result", {overflow, result}, 33'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].s);
         wait_valid(r);
         chk($sformatf("vec_%0d", i), r, {vecs[i].o, vecs[i].r});
      end
      @(posedge clk); #1;

      // Backpressure: output must hold while stray inputs are offered
      out_ready = 1'b0;
      issue(vecs[0].a, vecs[0].b, vecs[0].s);
      wait_valid(held);
      chk("bp_first", held, {vecs[0].o, vecs[0].r});
      in_valid = 1'b1;
      op_a = 32'h3F000000;
      op_b = 32'h3F000000;
      sub  = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         chk("bp_hold", {overflow, result}, held);
         chk("bp_hold_valid", {32'b0, out_valid}, 33'h1);
         chk("bp_in_ready", {32'b0, in_ready}, 33'h0);
      end
      op_a = vecs[2].a;
      op_b = vecs[2].b;
      sub  = vecs[2].s;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_accept_drop", {32'b0, out_valid}, 33'h0);
      wait_valid(r);
      chk("bp_second", r, {vecs[2].o, vecs[2].r});
      @(posedge clk); #1;

      // Reset during NORM discards the in-flight op
      issue(vecs[12].a, vecs[12].b, vecs[12].s);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_out_valid", {32'b0, out_valid}, 33'h0);
      chk("rst_result", {overflow, result}, 33'h0);
      chk("rst_in_ready", {32'b0, in_ready}, 33'h1);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("rst_no_output", 33'(seen), 33'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_add_sequencer.md
# fpu_add_sequencer

Multi-cycle controller for single-precision IEEE-754 add/subtract in the MIPS FPU. It accepts one operand pair over a valid/ready handshake and steps one shared datapath through five phases: capture/swap, align, add, normalize, round/pack. The phases reuse the FPU's existing shift-with-round and normalize arithmetic. The result is held on a valid/ready output port until it is consumed. It sits between the FPU register-file read stage and the FP writeback mux.

## Interface
Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept an operand pair.
- op_a  input  32  IEEE single operand A.
- op_b  input  32  IEEE single operand B.
- sub  input  1  1 selects A−B; 0 selects A+B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- result  output  32  IEEE single result.
- overflow  output  1  result saturated to ±inf; valid with out_valid.

## Operation
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE→ALIGN on accept (in_valid & in_ready).
  - Capture operands, with the sign of B inverted when sub=1.
  - Swap so that A has the larger magnitude, comparing {exp,frac}.
- ALIGN:
  - diff = expA − expB, unsigned, 8 bits.
  - Significands are 32-bit with the hidden 1 at bit 23.
  - Shift B right by diff. Add 1 if the last bit shifted out was 1 (guard round, ties away).
  - diff ≥ 25 forces B to 0.
- ADD:
  - Equal signs: sum = A + B.
  - Otherwise: sum = A − B. The result is never negative, because of the swap.
  - Result sign = sign of A.
- NORM:
  - sum = 0 → result +0; skip to ROUND unchanged.
  - Bit 24 set → shift right 1 with guard round; exp += 1.
  - Otherwise find the leading one at bit k < 23 → shift left 23−k; exp −= 23−k.
  - Exponent arithmetic is 10-bit signed.
- ROUND:
  - If rounding carried into bit 24, shift right 1 and exp += 1.
  - exp ≥ 255 → ±inf (0x7F800000 | sign), overflow=1.
  - exp ≤ 0 → ±0 (flush, no denormals).
  - Otherwise pack {sign, exp[7:0], sig[22:0]}.
- DONE: out_valid=1. result and overflow are held stable until out_ready.
- Special inputs:
  - Exponent 0 is treated as zero (flush-to-zero).
  - If either operand has exponent 255, the result is 0x7FC00000 when both operands are inf of opposite effective sign or either is NaN. Otherwise the result is the inf operand.
  - Special results are still delivered through DONE with the same latency.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0. All datapath registers are cleared.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Latency: out_valid rises 5 cycles after the accept edge.
- Phase occupancy: each of ALIGN, ADD, NORM and ROUND occupies exactly one cycle.
- DONE with out_ready=1 and in_valid=1: the result is consumed and the new pair is accepted on the same edge; next state is ALIGN. Peak throughput is one op per 5 cycles.
- DONE with out_ready=1 and in_valid=0: next state is IDLE; out_valid falls.
- out_ready=0 in DONE: remain in DONE indefinitely; no output changes.
- Inputs are ignored while in_ready=0. op_a, op_b and sub are sampled only on the accept edge.
- rst_n low in any state: return to reset values on that edge; the in-flight op is discarded with no output.

## Structure
- fpu_pkg holds:
  - the state enum (fpu_add_state_t);
  - EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, PINF=32'h7F800000;
  - the field-slice widths.
- One sub-module, fpu_lzc:
  - combinational leading-one detector over sum[23:0];
  - returns left-shift count 0–23 plus a zero flag;
  - used by NORM.
- The FSM, swap logic and shift/round logic live in fpu_add_sequencer.

## Test plan
- 0x3F800000 + 0x3F800000, sub=0, out_ready=1 → result 0x40000000, overflow=0, out_valid exactly 5 cycles after accept.
- 0x3FC00000 − 0x3FC00000 (sub=1) → 0x00000000. 0x40400000 − 0x40300000 → 0x3E800000 (left normalize by 3).
- 0x3F800000 + 0x30800000 (diff ≥ 25) → 0x3F800000. 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1.
- 0x7F800000 + 0xFF800000 → 0x7FC00000. 0x00000001 (denormal) + 0x3F800000 → 0x3F800000.
- Backpressure:
  - Hold out_ready=0 for 4 cycles after out_valid → result stable, in_ready=0.
  - Raise out_ready with in_valid=1 → the next op is accepted on the same edge, and its out_valid comes 5 cycles later.
- Pull rst_n low during NORM → next cycle state IDLE, out_valid=0, result=0, in_ready=1; the aborted op never appears.
